// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RV32 pipeline: M/W operand forwarding, load-use stall,
// branch flush, a single-entry scoreboard for the multi-cycle MDU, an optional
// no-forwarding interlock mode and saturating stall/flush performance counters.
module hazard_ctrl_unit #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MDU_LATENCY = 4,
  parameter int unsigned FWD_EN      = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic              MduOpD,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic              RegWriteE,
  input  logic              MemReadE,
  input  logic              PCSrcE,
  input  logic              MduStartE,
  input  logic [REG_AW-1:0] RD_M,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RD_W,
  input  logic              RegWriteW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              MduBusy,
  output logic              MduDone,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  localparam int unsigned MduCntW = $clog2(MDU_LATENCY);
  localparam logic [MduCntW-1:0] MduLoad = MduCntW'(MDU_LATENCY - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [0:0] {StIdle, StBusy} mdu_state_e;

  mdu_state_e        state_q, state_d;
  logic [MduCntW-1:0] cnt_q, cnt_d;
  logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic busy, done;
  logic lw_stall, il_stall, md_stall, stall;

  // Forward select for one E operand; M has priority over W, x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m, input logic we_m,
                                         input logic [REG_AW-1:0] rd_w, input logic we_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && rd_m != '0 && rd_m == rs) begin
      sel = 2'b10;
    end else if (we_w && rd_w != '0 && rd_w == rs) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // True when a nonzero D source is written by any in-flight E/M/W instruction.
  function automatic logic raw_hit(input logic [REG_AW-1:0] rs,
                                   input logic [REG_AW-1:0] rd_e, input logic we_e,
                                   input logic [REG_AW-1:0] rd_m, input logic we_m,
                                   input logic [REG_AW-1:0] rd_w, input logic we_w);
    return (rs != '0) && ((we_e && rs == rd_e) || (we_m && rs == rd_m) ||
                          (we_w && rs == rd_w));
  endfunction

  // MDU scoreboard next state: one outstanding op, counted down to its W-port cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_rd_d = pend_rd_q;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MduStartE) begin
          state_d   = StBusy;
          cnt_d     = MduLoad;
          pend_rd_d = RD_E;
        end
      end
      StBusy: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - MduCntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Hazard detection and pipeline control; everything held low while in reset.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    lw_stall  = 1'b0;
    il_stall  = 1'b0;
    md_stall  = 1'b0;
    stall     = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    MduBusy   = 1'b0;
    MduDone   = 1'b0;
    if (rst_n) begin
      if (FWD_EN != 0) begin
        ForwardAE = fwd_sel(Rs1_E, RD_M, RegWriteM, RD_W, RegWriteW);
        ForwardBE = fwd_sel(Rs2_E, RD_M, RegWriteM, RD_W, RegWriteW);
      end else begin
        il_stall = raw_hit(Rs1_D, RD_E, RegWriteE, RD_M, RegWriteM, RD_W, RegWriteW) ||
                   raw_hit(Rs2_D, RD_E, RegWriteE, RD_M, RegWriteM, RD_W, RegWriteW);
      end
      lw_stall = MemReadE && RD_E != '0 && (RD_E == Rs1_D || RD_E == Rs2_D);
      md_stall = busy && ((pend_rd_q != '0 && (pend_rd_q == Rs1_D || pend_rd_q == Rs2_D)) ||
                          MduOpD);
      // A taken branch squashes the D instruction, so stalling it is pointless.
      stall   = (lw_stall || il_stall || md_stall) && !PCSrcE;
      StallF  = stall;
      StallD  = stall;
      FlushD  = PCSrcE;
      FlushE  = stall || PCSrcE;
      MduBusy = busy;
      MduDone = done;
    end
  end

  // Saturating performance counter next values.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD && stall_cnt_q != CntMax) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (FlushD && flush_cnt_q != CntMax) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pend_rd_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_rd_q   <= pend_rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: three configurations share one stimulus stream;
// a spec-level reference model predicts each cycle's outputs into a queue that a
// separate monitor pops and compares at the falling edge.
module tb_hazard_ctrl_unit;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1_d, rs2_d;
    logic       mdu_op_d;
    logic [4:0] rs1_e, rs2_e, rd_e;
    logic       reg_write_e, mem_read_e, pc_src_e, mdu_start_e;
    logic [4:0] rd_m;
    logic       reg_write_m;
    logic [4:0] rd_w;
    logic       reg_write_w;
  } in_t;

  typedef struct packed {
    logic [2:0][9:0]  ctl;
    logic [2:0][15:0] scnt;
    logic [2:0][15:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t cur = '0;

  logic [9:0]  act_ctl [3];
  logic [15:0] act_sc  [3];
  logic [15:0] act_fc  [3];

  // DUT 0: forwarding, LAT 4. DUT 1: interlock mode, LAT 4. DUT 2: forwarding, LAT 2, CNT_W 2.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Fwd = (g == 1) ? 0 : 1;
    localparam int unsigned Lat = (g == 2) ? 2 : 4;
    localparam int unsigned Cw  = (g == 2) ? 2 : 16;
    logic [1:0] fa, fb;
    logic sf, sd, fd, fe, mb, md;
    logic [Cw-1:0] sc, fc;
    hazard_ctrl_unit #(.REG_AW(5), .MDU_LATENCY(Lat), .FWD_EN(Fwd), .CNT_W(Cw)) dut (
      .clk(clk), .rst_n(cur.rst_n),
      .Rs1_D(cur.rs1_d), .Rs2_D(cur.rs2_d), .MduOpD(cur.mdu_op_d),
      .Rs1_E(cur.rs1_e), .Rs2_E(cur.rs2_e), .RD_E(cur.rd_e),
      .RegWriteE(cur.reg_write_e), .MemReadE(cur.mem_read_e), .PCSrcE(cur.pc_src_e),
      .MduStartE(cur.mdu_start_e),
      .RD_M(cur.rd_m), .RegWriteM(cur.reg_write_m),
      .RD_W(cur.rd_w), .RegWriteW(cur.reg_write_w),
      .ForwardAE(fa), .ForwardBE(fb), .StallF(sf), .StallD(sd), .FlushD(fd), .FlushE(fe),
      .MduBusy(mb), .MduDone(md), .StallCnt(sc), .FlushCnt(fc)
    );
    assign act_ctl[g] = {fa, fb, sf, sd, fd, fe, mb, md};
    assign act_sc[g]  = 16'(sc);
    assign act_fc[g]  = 16'(fc);
  end

  // Reference model state: remaining busy cycles, pending rd, counter values.
  int unsigned lat_of [3] = '{4, 4, 2};
  bit          fwd_of [3] = '{1'b1, 1'b0, 1'b1};
  int unsigned max_of [3] = '{65535, 65535, 3};
  int unsigned busy_left [3] = '{0, 0, 0};
  logic [4:0]  pend [3] = '{5'd0, 5'd0, 5'd0};
  int unsigned sc_m [3] = '{0, 0, 0};
  int unsigned fc_m [3] = '{0, 0, 0};

  exp_t exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  function automatic logic [1:0] ref_fwd(input in_t i, input logic [4:0] rs);
    if (i.reg_write_m && i.rd_m != 0 && i.rd_m == rs) return 2'b10;
    if (i.reg_write_w && i.rd_w != 0 && i.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_hit(input in_t i, input logic [4:0] rs);
    return rs != 0 && ((i.reg_write_e && rs == i.rd_e) || (i.reg_write_m && rs == i.rd_m) ||
                       (i.reg_write_w && rs == i.rd_w));
  endfunction

  task automatic step_model(output exp_t e);
    e = '0;
    for (int d = 0; d < 3; d++) begin
      bit lw, il, md, st, busy, done;
      logic [1:0] fa, fb;
      e.scnt[d] = 16'(sc_m[d]);
      e.fcnt[d] = 16'(fc_m[d]);
      if (!cur.rst_n) begin
        e.ctl[d] = '0;
        busy_left[d] = 0;
        sc_m[d] = 0;
        fc_m[d] = 0;
      end else begin
        fa = fwd_of[d] ? ref_fwd(cur, cur.rs1_e) : 2'b00;
        fb = fwd_of[d] ? ref_fwd(cur, cur.rs2_e) : 2'b00;
        lw = cur.mem_read_e && cur.rd_e != 0 && (cur.rd_e == cur.rs1_d || cur.rd_e == cur.rs2_d);
        il = !fwd_of[d] && (ref_hit(cur, cur.rs1_d) || ref_hit(cur, cur.rs2_d));
        busy = busy_left[d] > 0;
        done = busy_left[d] == 1;
        md = busy && ((pend[d] != 0 && (pend[d] == cur.rs1_d || pend[d] == cur.rs2_d)) ||
                      cur.mdu_op_d);
        st = (lw || il || md) && !cur.pc_src_e;
        e.ctl[d] = {fa, fb, st, st, cur.pc_src_e, st || cur.pc_src_e, busy, done};
        if (busy_left[d] > 0) busy_left[d]--;
        else if (cur.mdu_start_e) begin
          busy_left[d] = lat_of[d];
          pend[d] = cur.rd_e;
        end
        if (st && sc_m[d] < max_of[d]) sc_m[d]++;
        if (cur.pc_src_e && fc_m[d] < max_of[d]) fc_m[d]++;
      end
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
  endtask

  // Apply one cycle of inputs just after the rising edge and queue the prediction.
  task automatic tick(input in_t i);
    exp_t e;
    @(posedge clk);
    #1;
    cur = i;
    cyc++;
    step_model(e);
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUTs present outputs; compare against the oldest prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int d = 0; d < 3; d++) begin
        check($sformatf("ctl%0d", d), 16'(act_ctl[d]), 16'(e.ctl[d]));
        check($sformatf("stallcnt%0d", d), act_sc[d], e.scnt[d]);
        check($sformatf("flushcnt%0d", d), act_fc[d], e.fcnt[d]);
      end
    end
  end

  function automatic in_t idle();
    in_t i;
    i = '0;
    i.rst_n = 1'b1;
    return i;
  endfunction

  initial begin
    in_t i;
    cur = '0;
    // Reset with noisy inputs: all control outputs must stay low.
    for (int k = 0; k < 3; k++) begin
      i = in_t'({$urandom, $urandom});
      i.rst_n = 1'b0;
      tick(i);
    end
    tick(idle());
    // M beats W, then W alone.
    i = idle(); i.rd_m = 5; i.rd_w = 5; i.reg_write_m = 1; i.reg_write_w = 1; i.rs1_e = 5;
    tick(i);
    i.reg_write_m = 0;
    tick(i);
    // x0 never forwards.
    i = idle(); i.rd_m = 0; i.reg_write_m = 1; i.rs2_e = 0;
    tick(i);
    // Load-use, then the same with a taken branch.
    i = idle(); i.mem_read_e = 1; i.rd_e = 7; i.rs2_d = 7;
    tick(i);
    tick(idle());
    i.pc_src_e = 1;
    tick(i);
    // MDU op with rd 9, dependent instruction held in D.
    i = idle(); i.mdu_start_e = 1; i.rd_e = 9;
    tick(i);
    for (int k = 0; k < 6; k++) begin
      i = idle(); i.rs1_d = 9;
      tick(i);
    end
    // Reset during an MDU operation.
    i = idle(); i.mdu_start_e = 1; i.rd_e = 3;
    tick(i);
    tick(idle());
    i = idle(); i.rst_n = 0;
    tick(i);
    for (int k = 0; k < 6; k++) tick(idle());
    // Counter saturation on the 2-bit configuration.
    for (int k = 0; k < 5; k++) begin
      i = idle(); i.mem_read_e = 1; i.rd_e = 4; i.rs1_d = 4;
      tick(i);
    end
    @(negedge clk);
    check("stallcnt_sat", act_sc[2], 16'd3);
    // Randomized traffic with small register indices for frequent matches.
    for (int k = 0; k < 3000; k++) begin
      i.rst_n       = ($urandom_range(63) != 0);
      i.rs1_d       = 5'($urandom_range(7));
      i.rs2_d       = 5'($urandom_range(7));
      i.mdu_op_d    = ($urandom_range(3) == 0);
      i.rs1_e       = 5'($urandom_range(7));
      i.rs2_e       = 5'($urandom_range(7));
      i.rd_e        = 5'($urandom_range(7));
      i.reg_write_e = 1'($urandom_range(1));
      i.mem_read_e  = ($urandom_range(3) == 0);
      i.pc_src_e    = ($urandom_range(7) == 0);
      i.mdu_start_e = !i.pc_src_e && ($urandom_range(5) == 0);
      i.rd_m        = 5'($urandom_range(7));
      i.reg_write_m = 1'($urandom_range(1));
      i.rd_w        = 5'($urandom_range(7));
      i.reg_write_w = 1'($urandom_range(1));
      tick(i);
    end
    @(negedge clk);
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
